hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipeline_pkg.sv | 45 ++++
 rtl/sat_counter.sv | 19 +
 rtl/hazard_ctrl.sv | 78 +++++++
 tb/tb_hazard_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings and hazard-tracking tag types.
package pipeline_pkg;

    localparam int unsigned REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } res_src_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        reg_idx_t rs1;
        reg_idx_t rs2;
        reg_idx_t rd;
        logic     regwrite;
        logic     isload;
    } e_tag_t;

    typedef struct packed {
        reg_idx_t rd;
        logic     regwrite;
    } wb_tag_t;

    // Memory stage wins over Writeback; x0 is never a forwarding source.
    function automatic fwd_sel_e fwd_select(input reg_idx_t rs, input wb_tag_t m, input wb_tag_t w);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (m.regwrite && (m.rd != '0) && (m.rd == rs)) begin
            sel = FWD_M;
        end else if (w.regwrite && (w.rd != '0) && (w.rd == rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: load-use stall, branch flush, E-stage
// operand forwarding, and saturating stall/flush event counters.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic             PCSrcE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    e_tag_t  tag_e;
    wb_tag_t tag_m;
    wb_tag_t tag_w;
    e_tag_t  tag_d;
    logic    lw_stall;

    // Reset masks the tags so nothing stale leaks out while it is held.
    always_comb begin
        tag_d    = '{rs1: Rs1D, rs2: Rs2D, rd: RdD,
                     regwrite: RegWriteD, isload: (ResultSrcD == RES_MEM)};
        lw_stall = ~reset & tag_e.isload & tag_e.regwrite & (tag_e.rd != '0)
                 & ((Rs1D == tag_e.rd) | (Rs2D == tag_e.rd));

        StallF    = lw_stall & ~PCSrcE;
        StallD    = lw_stall & ~PCSrcE;
        FlushD    = PCSrcE;
        FlushE    = lw_stall | PCSrcE;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (!reset) begin
            ForwardAE = fwd_select(tag_e.rs1, tag_m, tag_w);
            ForwardBE = fwd_select(tag_e.rs2, tag_m, tag_w);
        end
    end

    // Tags mirror the E/M/W pipeline registers; a flushed E slot becomes a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_e <= '0;
            tag_m <= '0;
            tag_w <= '0;
        end else begin
            tag_e <= FlushE ? e_tag_t'('0) : tag_d;
            tag_m <= '{rd: tag_e.rd, regwrite: tag_e.regwrite};
            tag_w <= tag_m;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (StallD),
        .count (StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (FlushD),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: per-cycle expectations are queued as each
// stimulus row is driven and compared against the DUT outputs mid-cycle.
module tb_hazard_ctrl;

    localparam logic [1:0] F_RF = 2'b00;
    localparam logic [1:0] F_W  = 2'b01;
    localparam logic [1:0] F_M  = 2'b10;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic [1:0] rsrc;
        logic       pc;
    } stim_t;

    typedef struct packed {
        logic        sf;
        logic        sd;
        logic        fd;
        logic        fe;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        RegWriteD;
    logic [1:0]  ResultSrcD;
    logic        PCSrcE;
    logic        StallF, StallD, FlushD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] StallCount, FlushCount;
    logic        s4_stallf, s4_stalld, s4_flushd, s4_flushe;
    logic [1:0]  s4_fa, s4_fb;
    logic [3:0]  s4_sc, s4_fc;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   exp4_q[$];

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
        .StallF(s4_stallf), .StallD(s4_stalld), .FlushD(s4_flushd), .FlushE(s4_flushe),
        .ForwardAE(s4_fa), .ForwardBE(s4_fb),
        .StallCount(s4_sc), .FlushCount(s4_fc)
    );

    always #5 clk = ~clk;

    function automatic stim_t st(input logic rst, input int rs1, input int rs2, input int rd,
                                 input logic rw, input int rsrc, input logic pc);
        return '{rst: rst, rs1: 5'(rs1), rs2: 5'(rs2), rd: 5'(rd), rw: rw,
                 rsrc: 2'(rsrc), pc: pc};
    endfunction

    function automatic exp_t ex(input logic stall, input logic fd, input logic fe,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input int sc, input int fc);
        return '{sf: stall, sd: stall, fd: fd, fe: fe, fa: fa, fb: fb,
                 sc: 16'(sc), fc: 16'(fc)};
    endfunction

    function automatic exp_t observe();
        return '{sf: StallF, sd: StallD, fd: FlushD, fe: FlushE, fa: ForwardAE,
                 fb: ForwardBE, sc: StallCount, fc: FlushCount};
    endfunction

    task automatic drive(input stim_t s, input exp_t e);
        reset      = s.rst;
        Rs1D       = s.rs1;
        Rs2D       = s.rs2;
        RdD        = s.rd;
        RegWriteD  = s.rw;
        ResultSrcD = s.rsrc;
        PCSrcE     = s.pc;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1; Rs1D = '0; Rs2D = '0; RdD = '0;
        RegWriteD = 1'b0; ResultSrcD = 2'b00; PCSrcE = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        stim_t s[3];
        exp_t  e[3];
        exp_t  got, want;
        s[0] = st(1, 0, 0, 0, 0, 0, 1); e[0] = ex(0, 1, 1, F_RF, F_RF, 0, 0);
        s[1] = st(0, 0, 0, 0, 0, 0, 1); e[1] = ex(0, 1, 1, F_RF, F_RF, 0, 0);
        s[2] = st(0, 0, 0, 0, 0, 0, 0); e[2] = ex(0, 0, 0, F_RF, F_RF, 0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset c%0d got=%h want=%h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t s[4];
        exp_t  e[4];
        exp_t  got, want;
        do_reset();
        s[0] = st(0, 1, 0, 5, 1, 1, 0); e[0] = ex(0, 0, 0, F_RF, F_RF, 0, 0);
        s[1] = st(0, 5, 7, 6, 1, 0, 0); e[1] = ex(1, 0, 1, F_RF, F_RF, 0, 0);
        s[2] = st(0, 5, 7, 6, 1, 0, 0); e[2] = ex(0, 0, 0, F_RF, F_RF, 1, 0);
        s[3] = st(0, 0, 0, 0, 0, 0, 0); e[3] = ex(0, 0, 0, F_W,  F_RF, 1, 0);
        for (int i = 0; i < 4; i++) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL load_use c%0d got=%h want=%h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_forward();
        stim_t s[7];
        exp_t  e[7];
        exp_t  got, want;
        do_reset();
        s[0] = st(0, 1, 2, 3, 1, 0, 0); e[0] = ex(0, 0, 0, F_RF, F_RF, 0, 0);
        s[1] = st(0, 3, 3, 4, 1, 0, 0); e[1] = ex(0, 0, 0, F_RF, F_RF, 0, 0);
        s[2] = st(0, 0, 0, 0, 0, 0, 0); e[2] = ex(0, 0, 0, F_M,  F_M,  0, 0);
        s[3] = st(0, 1, 2, 3, 1, 0, 0); e[3] = ex(0, 0, 0, F_RF, F_RF, 0, 0);
        s[4] = st(0, 0, 0, 0, 0, 0, 0); e[4] = ex(0, 0, 0, F_RF, F_RF, 0, 0);
        s[5] = st(0, 3, 3, 4, 1, 0, 0); e[5] = ex(0, 0, 0, F_RF, F_RF, 0, 0);
        s[6] = st(0, 0, 0, 0, 0, 0, 0); e[6] = ex(0, 0, 0, F_W,  F_W,  0, 0);
        for (int i = 0; i < 7; i++) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL forward c%0d got=%h want=%h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_priority_x0();
        stim_t s[10];
        exp_t  e[10];
        exp_t  got, want;
        do_reset();
        s[0] = st(0, 1, 0, 9,  1, 0, 0); e[0] = ex(0, 0, 0, F_RF, F_RF, 0, 0);
        s[1] = st(0, 2, 0, 9,  1, 0, 0); e[1] = ex(0, 0, 0, F_RF, F_RF, 0, 0);
        s[2] = st(0, 9, 0, 10, 1, 0, 0); e[2] = ex(0, 0, 0, F_RF, F_RF, 0, 0);
        s[3] = st(0, 0, 0, 0,  0, 0, 0); e[3] = ex(0, 0, 0, F_M,  F_RF, 0, 0);
        s[4] = st(0, 1, 0, 0,  1, 0, 0); e[4] = ex(0, 0, 0, F_RF, F_RF, 0, 0);
        s[5] = st(0, 1, 0, 0,  1, 0, 0); e[5] = ex(0, 0, 0, F_RF, F_RF, 0, 0);
        s[6] = st(0, 0, 0, 0,  1, 0, 0); e[6] = ex(0, 0, 0, F_RF, F_RF, 0, 0);
        s[7] = st(0, 0, 0, 0,  0, 0, 0); e[7] = ex(0, 0, 0, F_RF, F_RF, 0, 0);
        s[8] = st(0, 0, 0, 0,  1, 1, 0); e[8] = ex(0, 0, 0, F_RF, F_RF, 0, 0);
        s[9] = st(0, 0, 0, 6,  1, 0, 0); e[9] = ex(0, 0, 0, F_RF, F_RF, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL prio_x0 c%0d got=%h want=%h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_over_stall();
        stim_t s[3];
        exp_t  e[3];
        exp_t  got, want;
        do_reset();
        s[0] = st(0, 1, 0, 5, 1, 1, 0); e[0] = ex(0, 0, 0, F_RF, F_RF, 0, 0);
        s[1] = st(0, 5, 7, 6, 1, 0, 1); e[1] = ex(0, 1, 1, F_RF, F_RF, 0, 0);
        s[2] = st(0, 0, 0, 0, 0, 0, 0); e[2] = ex(0, 0, 0, F_RF, F_RF, 0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL branch c%0d got=%h want=%h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        stim_t s[8];
        exp_t  e[8];
        exp_t  got, want;
        do_reset();
        s[0] = st(0, 0, 0, 0, 0, 0, 1); e[0] = ex(0, 1, 1, F_RF, F_RF, 0, 0);
        s[1] = st(0, 1, 0, 5, 1, 1, 0); e[1] = ex(0, 0, 0, F_RF, F_RF, 0, 1);
        s[2] = st(0, 5, 7, 5, 1, 0, 0); e[2] = ex(1, 0, 1, F_RF, F_RF, 0, 1);
        s[3] = st(0, 5, 7, 5, 1, 0, 0); e[3] = ex(0, 0, 0, F_RF, F_RF, 1, 1);
        s[4] = st(0, 5, 0, 8, 1, 1, 0); e[4] = ex(0, 0, 0, F_W,  F_RF, 1, 1);
        s[5] = st(1, 8, 0, 9, 1, 0, 0); e[5] = ex(0, 0, 0, F_RF, F_RF, 1, 1);
        s[6] = st(0, 8, 0, 9, 1, 0, 0); e[6] = ex(0, 0, 0, F_RF, F_RF, 0, 0);
        s[7] = st(0, 0, 0, 0, 0, 0, 0); e[7] = ex(0, 0, 0, F_RF, F_RF, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got  = observe();
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset_mid c%0d got=%h want=%h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturate();
        int exp4;
        int exp16;
        int want4;
        do_reset();
        exp4  = 0;
        exp16 = 0;
        for (int i = 0; i <= 20; i++) begin
            drive(st(0, 0, 0, 0, 0, 0, (i < 20) ? 1'b1 : 1'b0),
                  ex(0, (i < 20) ? 1'b1 : 1'b0, (i < 20) ? 1'b1 : 1'b0, F_RF, F_RF, 0, exp16));
            exp4_q.push_back(exp4);
            @(negedge clk);
            void'(exp_q.pop_front());
            want4 = exp4_q.pop_front();
            total++;
            if ({s4_fc, FlushCount} !== {4'(want4), 16'(exp16)}) begin
                bad++;
                $display("FAIL saturate c%0d got=%0d/%0d want=%0d/%0d",
                         i, s4_fc, FlushCount, want4, exp16);
            end
            if (i < 20) begin
                exp16++;
                if (exp4 != 15) exp4++;
            end
            @(posedge clk); #1;
        end
        total++;
        if (s4_fc !== 4'd15) begin
            bad++;
            $display("FAIL saturate_final got=%0d want=15", s4_fc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        clk = 1'b0;
        reset = 1'b1; Rs1D = '0; Rs2D = '0; RdD = '0;
        RegWriteD = 1'b0; ResultSrcD = 2'b00; PCSrcE = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_forward();
        test_priority_x0();
        test_branch_over_stall();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
